// File: rtl/cfg_loader_pkg.sv
// Shared types and default sizing for the configuration stream loader.
// Holds the loader state enum, default parameters and a counter-width helper.
package cfg_loader_pkg;

    localparam int DEF_WORD_W        = 32;
    localparam int DEF_FRAME_W       = 320;
    localparam int DEF_NUM_FRAMES    = 172;
    localparam int DEF_SETTLE_CYCLES = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_APPLY,
        S_ADVANCE,
        S_SETTLE,
        S_DONE
    } state_t;

    // Width able to hold 0..range-1, never narrower than one bit.
    function automatic int cnt_w(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/cfg_frame_asm.sv
// Assembles stream words into one frame-wide shadow register.
// Ports: clock, rst (async low), clr, accept, word -> shadow, frame_full.
module cfg_frame_asm
    import cfg_loader_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int FRAME_W = DEF_FRAME_W
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               clr,
    input  logic               accept,
    input  logic [WORD_W-1:0]  word,
    output logic [FRAME_W-1:0] shadow,
    output logic               frame_full
);

    localparam int WORDS = FRAME_W / WORD_W;
    localparam int CW    = cnt_w(WORDS);

    if ((FRAME_W % WORD_W) != 0 || WORDS < 1) begin : g_bad_w
        $error("FRAME_W must be a positive multiple of WORD_W");
    end

    logic [CW-1:0]      word_cnt_q, word_cnt_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic               last_w;

    assign last_w = (word_cnt_q == CW'(WORDS - 1));

    always_comb begin
        shadow_d   = shadow_q;
        word_cnt_d = word_cnt_q;
        if (clr) begin
            word_cnt_d = '0;
        end else if (accept) begin
            // Word k lands at slice k; word 0 is least significant.
            for (int k = 0; k < WORDS; k++) begin
                if (word_cnt_q == CW'(k))
                    shadow_d[k*WORD_W +: WORD_W] = word;
            end
            word_cnt_d = last_w ? '0 : word_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            shadow_q   <= '0;
            word_cnt_q <= '0;
        end else begin
            shadow_q   <= shadow_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign shadow     = shadow_q;
    assign frame_full = accept & last_w & ~clr;

endmodule

// File: rtl/cfg_stream_loader.sv
// Streams a bitstream into the fabric frame by frame, then enables it.
// Ports: cfg_data/valid/ready in, configs_in/en, ff_en, rdy, busy out.
module cfg_stream_loader
    import cfg_loader_pkg::*;
#(
    parameter int WORD_W        = DEF_WORD_W,
    parameter int FRAME_W       = DEF_FRAME_W,
    parameter int NUM_FRAMES    = DEF_NUM_FRAMES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_W-1:0]     cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [FRAME_W-1:0]    configs_in,
    output logic [NUM_FRAMES-1:0] configs_en,
    output logic                  ff_en,
    output logic                  rdy,
    output logic                  busy
);

    // frame_cnt reaches NUM_FRAMES after the final advance.
    localparam int FCW = cnt_w(NUM_FRAMES + 1);
    localparam int SCW = cnt_w(SETTLE_CYCLES);

    if (NUM_FRAMES < 1 || SETTLE_CYCLES < 1) begin : g_bad_p
        $error("NUM_FRAMES and SETTLE_CYCLES must be at least 1");
    end

    state_t                state_q;
    logic [FCW-1:0]        frame_cnt_q;
    logic [SCW-1:0]        settle_cnt_q;
    logic [FRAME_W-1:0]    configs_in_q;
    logic [NUM_FRAMES-1:0] configs_en_q;
    logic                  ff_en_q, rdy_q;
    logic                  cfg_ready_q, busy_q;

    logic                  restart, accept, frame_full;
    logic [FRAME_W-1:0]    shadow;

    assign restart = start &
                     ((state_q == S_IDLE) || (state_q == S_DONE));
    assign accept  = cfg_valid & cfg_ready_q;

    cfg_frame_asm #(
        .WORD_W  (WORD_W),
        .FRAME_W (FRAME_W)
    ) u_asm (
        .clock      (clock),
        .rst        (rst),
        .clr        (restart),
        .accept     (accept),
        .word       (cfg_data),
        .shadow     (shadow),
        .frame_full (frame_full)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            frame_cnt_q  <= '0;
            settle_cnt_q <= '0;
            configs_in_q <= '0;
            configs_en_q <= NUM_FRAMES'(1);
            ff_en_q      <= 1'b0;
            rdy_q        <= 1'b0;
            cfg_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_FILL;
                        frame_cnt_q  <= '0;
                        settle_cnt_q <= '0;
                        configs_en_q <= NUM_FRAMES'(1);
                        ff_en_q      <= 1'b0;
                        rdy_q        <= 1'b0;
                        cfg_ready_q  <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (frame_full) begin
                        state_q     <= S_APPLY;
                        cfg_ready_q <= 1'b0;
                    end
                end
                S_APPLY: begin
                    configs_in_q <= shadow;
                    state_q      <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    configs_en_q <= configs_en_q << 1;
                    frame_cnt_q  <= frame_cnt_q + FCW'(1);
                    if (frame_cnt_q == FCW'(NUM_FRAMES - 1)) begin
                        state_q      <= S_SETTLE;
                        settle_cnt_q <= '0;
                    end else begin
                        state_q     <= S_FILL;
                        cfg_ready_q <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    // ff_en already up means this is the extra rdy cycle.
                    if (ff_en_q) begin
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else if (settle_cnt_q == SCW'(SETTLE_CYCLES - 1)) begin
                        ff_en_q <= 1'b1;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SCW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign configs_in = configs_in_q;
    assign configs_en = configs_en_q;
    assign ff_en      = ff_en_q;
    assign rdy        = rdy_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Scoreboard bench for cfg_stream_loader with directed full loads.
// Expected frames are queued at start; a negedge monitor pops and compares.
module tb_cfg_stream_loader;

    localparam int WW  = 32;
    localparam int FW  = 320;
    localparam int NF  = 172;
    localparam int WPF = FW / WW;
    localparam int NW  = NF * WPF;

    logic          clock;
    logic          rst;
    logic          start;
    logic [WW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [FW-1:0] configs_in;
    logic [NF-1:0] configs_en;
    logic          ff_en;
    logic          rdy;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [FW-1:0] exp_q[$];
    logic [NF-1:0] en_q[$];
    logic [FW-1:0] prev_in = '0;
    logic [FW-1:0] m_fr;
    logic [NF-1:0] m_en;

    cfg_stream_loader #(
        .WORD_W        (WW),
        .FRAME_W       (FW),
        .NUM_FRAMES    (NF),
        .SETTLE_CYCLES (10)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .configs_in (configs_in),
        .configs_en (configs_en),
        .ff_en      (ff_en),
        .rdy        (rdy),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0b exp=%0b", nm, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_frame(input int f);
        logic [FW-1:0] fr;
        fr = '0;
        for (int k = 0; k < WPF; k++)
            fr[k*WW +: WW] = WW'(f * WPF + k);
        return fr;
    endfunction

    // Monitor: a new configs_in value while busy is one applied frame.
    always @(negedge clock) begin
        if (rst && busy && configs_in != prev_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty act=%0h exp=none", configs_in);
            end else begin
                m_fr = exp_q.pop_front();
                m_en = en_q.pop_front();
                chk("frame_data", configs_in, m_fr);
                chk("frame_en", FW'(configs_en), FW'(m_en));
            end
        end
        prev_in <= configs_in;
    end

    task automatic reset_checks(input string tag);
        chk1({tag, "_ready"}, cfg_ready, 1'b0);
        chk1({tag, "_ff_en"}, ff_en, 1'b0);
        chk1({tag, "_rdy"}, rdy, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_en"}, FW'(configs_en), FW'(1));
        chk({tag, "_in"}, configs_in, '0);
    endtask

    task automatic run_load(input bit bp, input int abort_at,
                            input int start_at);
        int i, cyc, n;
        bit fire, pulsed;
        logic [NF-1:0] oh;
        for (int f = 0; f < NF; f++) begin
            oh = '0;
            oh[f] = 1'b1;
            exp_q.push_back(mk_frame(f));
            en_q.push_back(oh);
        end
        @(negedge clock);
        start = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clock);
        start = 1'b0;
        chk1("go_ready", cfg_ready, 1'b1);
        chk1("go_ff_en", ff_en, 1'b0);
        chk1("go_rdy", rdy, 1'b0);
        chk1("go_busy", busy, 1'b1);
        chk("go_en", FW'(configs_en), FW'(1));
        i = 0;
        cyc = 0;
        pulsed = 1'b0;
        while (i < NW) begin
            if (i == abort_at) begin
                rst = 1'b0;
                #1;
                reset_checks("abort");
                exp_q.delete();
                en_q.delete();
                cfg_valid = 1'b0;
                @(negedge clock);
                rst = 1'b1;
                repeat (3) @(negedge clock);
                chk1("abort_stays_idle", busy, 1'b0);
                return;
            end
            start = (i == start_at) && !pulsed;
            if (start) pulsed = 1'b1;
            cfg_data = WW'(i);
            cfg_valid = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
            fire = cfg_valid && cfg_ready;
            @(negedge clock);
            if (fire) i++;
            cyc++;
            if (cyc > 30000) begin
                checks++;
                errors++;
                $display("FAIL drv_timeout act=%0d exp=%0d", i, NW);
                break;
            end
        end
        cfg_valid = 1'b0;
        start = 1'b0;
        n = 0;
        while (configs_en != '0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("en_zero", FW'(configs_en), '0);
        n = 0;
        while (!ff_en && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("ff_en_delay", FW'(n), FW'(10));
        chk1("rdy_before", rdy, 1'b0);
        @(negedge clock);
        chk1("done_rdy", rdy, 1'b1);
        chk1("done_ff_en", ff_en, 1'b1);
        chk1("done_busy", busy, 1'b0);
        chk1("done_ready", cfg_ready, 1'b0);
        chk("done_in", configs_in, mk_frame(NF - 1));
        repeat (3) @(negedge clock);
        chk1("hold_rdy", rdy, 1'b1);
        chk("hold_en", FW'(configs_en), '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        #2 rst = 1'b0;
        #1;
        reset_checks("rst");
        repeat (2) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        chk1("idle_busy", busy, 1'b0);
        run_load(1'b0, -1, -1);
        run_load(1'b0, -1, 50 * WPF + 2);
        run_load(1'b1, -1, -1);
        run_load(1'b0, 80 * WPF + 3, -1);
        run_load(1'b0, -1, -1);
        chk("sb_drained", FW'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
